serial_adder: RTL and testbench



---
 rtl/serial_pkg.sv | 12 +
 rtl/fa_bit.sv | 16 +
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell; the only arithmetic in the serial datapath.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_s;

    assign p_s = x ^ y;
    assign s   = p_s ^ ci;
    assign co  = (x & y) | (ci & p_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake toward the controller.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    sa_state_t        state_r;
    logic [WIDTH-1:0] sreg_a_r;
    logic [WIDTH-1:0] sreg_b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             s_s;
    logic             co_s;

    fa_bit u_fa (
        .x  (sreg_a_r[0]),
        .y  (sreg_b_r[0]),
        .ci (carry_r),
        .s  (s_s),
        .co (co_s)
    );

    // Control FSM and serial datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sreg_a_r <= {WIDTH{1'b0}};
            sreg_b_r <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sreg_a_r <= a;
                        sreg_b_r <= b;
                        carry_r  <= cin;
                        sum_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    carry_r  <= co_s;
                    sum_r    <= {s_s, sum_r[WIDTH-1:1]};
                    sreg_a_r <= {1'b0, sreg_a_r[WIDTH-1:1]};
                    sreg_b_r <= {1'b0, sreg_b_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        cout_r  <= co_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder, plus exhaustive check of fa_bit.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    logic fx, fy, fci, fs, fco;

    logic [8:0] sb[$];
    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    fa_bit u_fa (.x(fx), .y(fy), .ci(fci), .s(fs), .co(fco));

    always #5 clk = ~clk;

    // Count done pulses independently of the directed sequence.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        sb.push_back(9'(ta) + 9'(tb_) + 9'(tc));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns number of falling edges until done is seen (-1 on timeout) and busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [8:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
            check({tag, "_cout"}, 32'(cout), 32'(exp[8]));
        end
    endtask

    initial begin
        int lat, bc, d0;
        logic [2:0] v;
        logic [1:0] fexp;

        // Standalone full-adder cell, all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fx = v[0]; fy = v[1]; fci = v[2];
            fexp = 2'(fx) + 2'(fy) + 2'(fci);
            #1 check($sformatf("fa_%0d", i), 32'({fco, fs}), 32'(fexp));
        end

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add, latency and busy width.
        launch(8'h0F, 8'h01, 1'b0);
        wait_done(lat, bc);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cycles", 32'(bc), 32'd8);
        check_result("t1");
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'h0);

        launch(8'hFF, 8'h01, 1'b0);
        wait_done(lat, bc);
        check("t2_latency", 32'(lat), 32'd9);
        check_result("t2");
        @(negedge clk);

        launch(8'hFF, 8'hFF, 1'b1);
        wait_done(lat, bc);
        check_result("t3a");
        @(negedge clk);
        launch(8'h00, 8'h00, 1'b0);
        wait_done(lat, bc);
        check_result("t3b");
        @(negedge clk);

        // Start and new operands during SHIFT are ignored.
        d0 = done_cnt;
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("t4_latency", 32'(lat), 32'd5);
        check_result("t4");
        repeat (12) @(negedge clk);
        check("t4_single_done", 32'(done_cnt - d0), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'h0);
        check("t4_hold_sum", 32'(sum), 32'h46);

        // Asynchronous reset mid-add, then start already high at release.
        launch(8'h80, 8'h80, 1'b0);
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_sum", 32'(sum), 32'h0);
        check("t5_rst_cout", 32'(cout), 32'h0);
        check("t5_rst_done", 32'(done), 32'h0);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b0;
        sb.push_back(9'h100);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        check("t5_latency", 32'(lat), 32'd9);
        check_result("t5");
        @(negedge clk);

        // Start held high: back-to-back adds every WIDTH+2 cycles.
        a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
        sb.push_back(9'h004);
        @(posedge clk);
        wait_done(lat, bc);
        check("t6_latency0", 32'(lat), 32'd9);
        check_result("t6_0");
        for (int k = 1; k <= 2; k++) begin
            sb.push_back(9'h004);
            wait_done(lat, bc);
            check($sformatf("t6_period%0d", k), 32'(lat), 32'd10);
            check_result($sformatf("t6_%0d", k));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'h0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
